// File: rtl/uart_tx_param_if.sv
// Producer-side handshake bundle for uart_tx_param: word, valid and ready.
// The producer drives through the master modport and the transmitter uses the slave modport.
interface uart_tx_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_in;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (
      output data_in,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  data_in,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with an input FIFO and a valid/ready push port.
// Optional line break: define UART_TX_BREAK_EN to add the tx_break input.
module uart_tx_param #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        tx_clk,
   input  logic                        reset,
   uart_tx_param_if.slave              host,
   output logic                        data_out,
   output logic                        tx_idle,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef UART_TX_BREAK_EN
   ,
   input  logic                        tx_break
`endif
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic              STOP_LAST  = 1'(STOP_BITS - 1);
   localparam logic              ODD_PAR    = (PARITY == 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;
   logic [CNT_W-1:0]     count_next;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic [DATA_BITS-1:0] head;

   // Frame sequencer
   state_t               state;
   logic [BAUD_W-1:0]    baud;
   logic [BIT_W-1:0]     bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 parity_bit;
   logic                 baud_last;
   logic                 frame_end;
   logic                 brk;
   logic                 break_q;

`ifdef UART_TX_BREAK_EN
   assign brk = tx_break;
`else
   assign brk = 1'b0;
`endif

   assign full          = (count == FULL_COUNT);
   assign empty         = (count == '0);
   // Ready looks only at the registered count, so a pop in a full cycle never frees a slot.
   assign host.tx_ready = !full;
   assign push          = host.tx_valid && !full;
   assign head          = mem[rd_ptr];
   assign fifo_count    = count;

   assign baud_last = (baud == BAUD_LAST);
   assign frame_end = (state == STOP) && baud_last && (stop_idx == STOP_LAST);

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      pop = 1'b0;
      if (!empty && !brk) begin
         case (state)
            IDLE:    pop = !break_q;
            STOP:    pop = frame_end;
            default: pop = 1'b0;
         endcase
      end
   end

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // NOTE: the storage array is not reset; the pointers and count alone define which entries are live.
   always_ff @(posedge tx_clk) begin
      if (push) begin
         mem[wr_ptr] <= host.data_in;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge tx_clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_next;
      end
   end

   always_ff @(posedge tx_clk) begin
      if (reset) begin
         state      <= IDLE;
         data_out   <= 1'b1;
         tx_idle    <= 1'b1;
         baud       <= '0;
         bit_idx    <= '0;
         stop_idx   <= 1'b0;
         shift      <= '0;
         parity_bit <= 1'b0;
         break_q    <= 1'b0;
      end else begin
         tx_idle <= 1'b0;
         if (state != IDLE) begin
            baud <= baud_last ? '0 : baud + 1'b1;
         end

         case (state)
            IDLE: begin
               baud <= '0;
               if (pop) begin
                  shift      <= head;
                  parity_bit <= (^head) ^ ODD_PAR;
                  data_out   <= 1'b0;
                  state      <= START;
               end else if (brk) begin
                  data_out <= 1'b0;
                  break_q  <= 1'b1;
               end else begin
                  // Leaving a break spends one edge back at mark before the next pop.
                  data_out <= 1'b1;
                  break_q  <= 1'b0;
                  tx_idle  <= (count_next == '0);
               end
            end

            START: begin
               if (baud_last) begin
                  data_out <= shift[0];
                  bit_idx  <= '0;
                  state    <= DATA;
               end
            end

            DATA: begin
               if (baud_last) begin
                  if (bit_idx == BIT_LAST) begin
                     if (PARITY != 0) begin
                        data_out <= parity_bit;
                        state    <= PAR;
                     end else begin
                        data_out <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= STOP;
                     end
                  end else begin
                     bit_idx  <= bit_idx + 1'b1;
                     shift    <= shift >> 1;
                     data_out <= shift[1];
                  end
               end
            end

            PAR: begin
               if (baud_last) begin
                  data_out <= 1'b1;
                  stop_idx <= 1'b0;
                  state    <= STOP;
               end
            end

            STOP: begin
               if (baud_last) begin
                  if (!frame_end) begin
                     stop_idx <= 1'b1;
                  end else if (pop) begin
                     shift      <= head;
                     parity_bit <= (^head) ^ ODD_PAR;
                     data_out   <= 1'b0;
                     state      <= START;
                  end else begin
                     state   <= IDLE;
                     tx_idle <= (count_next == '0) && !brk;
                  end
               end
            end

            default: begin
               state    <= IDLE;
               data_out <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised serial transmitter for the host link; successor to the fixed 8N1 single-byte transmitter.
- Adds a configurable data width, baud divider, parity and stop-bit count, and a small input FIFO so the producer can queue words back-to-back.
- Uses a valid/ready handshake in place of a level-held start.
- Sits between the result-drain logic of the array and the board TX pin.

Parameters:
- DATA_BITS, 8, data bits per frame, range 5..9, sent LSB first.
- CLKS_PER_BIT, 16, tx_clk cycles per serial bit, minimum 1.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame, 1 or 2.
- FIFO_DEPTH, 4, input FIFO entries; must be a power of 2, minimum 2.

Ports:
- tx_clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of tx_clk.
- data_in  in  DATA_BITS  word to transmit.
- tx_valid  in  1  data_in is valid this cycle.
- tx_ready  out  1  FIFO can accept a word this cycle; equals !fifo_full.
- data_out  out  1  serial line, registered; idles high.
- tx_idle  out  1  high when the FSM is in IDLE and the FIFO is empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of words currently queued.

Behaviour:
- Reset (synchronous): after the reset edge, data_out=1, tx_ready=1, tx_idle=1, fifo_count=0, FSM=IDLE, FIFO flushed.
- Reset asserted mid-frame aborts the frame: data_out=1 from the next edge, and queued words are discarded.
- Push: a word is written on an edge where tx_valid && tx_ready.
  - tx_ready depends only on the registered count.
  - When full, a same-cycle pop does NOT make room for a push in that cycle.
  - tx_valid while full is ignored. No overflow occurs and no error flag is raised.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: when the FIFO is non-empty, pop the head into the shift register, set data_out=0 and go to START, all on one edge.
  - Word accepted at edge N into an empty FIFO in IDLE → data_out falls at edge N+1.
- Bit timing:
  - Every state except IDLE lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that runs 0..CLKS_PER_BIT-1.
  - START → DATA.
  - DATA emits DATA_BITS bits LSB first, one bit per period.
  - DATA → PAR if PARITY≠0, otherwise → STOP.
  - PAR emits the parity bit. Even mode: XOR of the data bits. Odd mode: inverted XOR.
  - STOP holds data_out=1 for STOP_BITS×CLKS_PER_BIT cycles.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- End of STOP:
  - FIFO non-empty → go directly to START with the next word. No idle gap; data_out falls on the edge that ends STOP.
  - FIFO empty → go to IDLE.
- data_in is captured at push time; later changes to data_in do not affect a queued word.
- FIFO: circular read and write pointers with wrap-around at FIFO_DEPTH. fifo_count is updated by push, pop or both on each edge.
- tx_idle is registered and goes high on the edge that returns the FSM to IDLE with the FIFO empty.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- With the macro defined, the block adds an input port tx_break (1 bit).
  - While tx_break=1 and the FSM is in IDLE, data_out=0 and no pop occurs.
  - A frame in progress completes first; break takes effect at the next IDLE.
  - tx_idle=0 during break.
  - Releasing tx_break returns data_out=1 on the next edge. Normal popping resumes one edge later.
- Without the macro: no tx_break port, and data_out in IDLE is always 1.

Test Plan:
- Defaults with CLKS_PER_BIT=4; reset then push 0xA5 → data_out falls 1 edge after acceptance and holds 4 cycles. Bits observed: 1,0,1,0,0,1,0,1. Stop is high for 4 cycles, then tx_idle=1. Total frame is 40 cycles.
- PARITY=2, push 0x07 → parity bit 1. PARITY=1, push 0x07 → parity bit 0. STOP_BITS=2 → stop high for 8 cycles. Frame length is 48 cycles.
- FIFO_DEPTH=4, tx_valid held with 0x11,0x22,… while the first frame is active → tx_ready=0 once fifo_count=4. Further words are dropped. Five frames go out back-to-back, with no high gap between the stop of one frame and the start of the next.
- Assert reset at cycle 13 of a frame with 2 words queued → data_out=1 and fifo_count=0 after the edge. No further frames appear. tx_ready=1.
- DATA_BITS=9, push 0x1FF → 9 high data bits, then stop, with correct frame length (44 cycles at CLKS_PER_BIT=4).
- UART_TX_BREAK_EN: assert tx_break mid-frame with 1 word queued → the current frame finishes, then data_out=0 while tx_break=1. After release, data_out=1 for one edge, then the queued frame starts.
